// File: rtl/matmul_result_drain_pkg.sv
// Shared sizes and types for the matrix-multiply result drain.
package matmul_pkg;

  localparam int unsigned BITS  = 8;
  localparam int unsigned DIM   = 32;
  localparam int unsigned IDX_W = $clog2(DIM);

  typedef logic [IDX_W:0]   dim_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

endpackage

// File: rtl/matmul_result_drain_rc_walker.sv
// Row-major row/column walker over an m x p region; load restarts at (0,0).
module rc_walker #(
  parameter int unsigned IDX_W = matmul_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic [IDX_W:0]   m,
  input  logic [IDX_W:0]   p,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last,
  output logic [IDX_W-1:0] row_nxt_c,
  output logic [IDX_W-1:0] col_nxt_c
);

  logic [IDX_W:0]   m_q, m_d;
  logic [IDX_W:0]   p_q, p_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             last_q, last_d;
  logic             col_end;
  logic             last_nxt;

  // Next position; stepping past the last element parks the walker at (0,0).
  always_comb begin
    col_end   = ({1'b0, col_q} == (p_q - (IDX_W+1)'(1)));
    row_nxt_c = row_q;
    col_nxt_c = col_q + IDX_W'(1);
    if (last_q) begin
      row_nxt_c = '0;
      col_nxt_c = '0;
    end else if (col_end) begin
      row_nxt_c = row_q + IDX_W'(1);
      col_nxt_c = '0;
    end
    last_nxt = !last_q
             && ({1'b0, row_nxt_c} == (m_q - (IDX_W+1)'(1)))
             && ({1'b0, col_nxt_c} == (p_q - (IDX_W+1)'(1)));
  end

  always_comb begin
    m_d    = m_q;
    p_d    = p_q;
    row_d  = row_q;
    col_d  = col_q;
    last_d = last_q;
    if (load) begin
      m_d    = m;
      p_d    = p;
      row_d  = '0;
      col_d  = '0;
      last_d = (m == (IDX_W+1)'(1)) && (p == (IDX_W+1)'(1));
    end else if (advance) begin
      row_d  = row_nxt_c;
      col_d  = col_nxt_c;
      last_d = last_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      p_q    <= '0;
      row_q  <= '0;
      col_q  <= '0;
      last_q <= 1'b0;
    end else begin
      m_q    <= m_d;
      p_q    <= p_d;
      row_q  <= row_d;
      col_q  <= col_d;
      last_q <= last_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = last_q;

endmodule

// File: rtl/matmul_result_drain.sv
// Snapshots the accelerator result matrix on done_in and streams the active
// m x p region out row-major over valid/ready, with optional ReLU.
module matmul_result_drain #(
  parameter int unsigned BITS = matmul_pkg::BITS,
  parameter int unsigned DIM  = matmul_pkg::DIM
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 done_in,
  input  logic [$clog2(DIM):0]                 m_in,
  input  logic [$clog2(DIM):0]                 p_in,
  input  logic [DIM-1:0][DIM-1:0][BITS-1:0]    data_in,
  input  logic                                 relu_en,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [BITS-1:0]                      out_data,
  output logic [$clog2(DIM)-1:0]               out_row,
  output logic [$clog2(DIM)-1:0]               out_col,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 overflow
);

  import matmul_pkg::*;

  localparam int unsigned IW = $clog2(DIM);

  drain_state_t state_q, state_d;

  logic [DIM-1:0][DIM-1:0][BITS-1:0] cap_q, cap_d;
  logic                              relu_q, relu_d;
  logic [BITS-1:0]                   out_data_q, out_data_d;
  logic                              out_valid_q, out_valid_d;
  logic                              busy_q, busy_d;
  logic                              overflow_q, overflow_d;

  logic [IW:0]   m_cl, p_cl;
  logic          size_ok;
  logic          xfer;
  logic          load;
  logic          advance;
  logic [IW-1:0] row_w, col_w;
  logic          last_w;
  logic [IW-1:0] row_nxt, col_nxt;

  function automatic logic [BITS-1:0] relu_f(input logic [BITS-1:0] v, input logic en);
    return (en && v[BITS-1]) ? '0 : v;
  endfunction

  // Oversized requests are clamped to the physical array size.
  always_comb begin
    m_cl    = (m_in > (IW+1)'(DIM)) ? (IW+1)'(DIM) : m_in;
    p_cl    = (p_in > (IW+1)'(DIM)) ? (IW+1)'(DIM) : p_in;
    size_ok = (m_in != '0) && (p_in != '0);
    xfer    = out_valid_q && out_ready;
  end

  rc_walker #(
    .IDX_W (IW)
  ) u_walker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .advance   (advance),
    .m         (m_cl),
    .p         (p_cl),
    .row       (row_w),
    .col       (col_w),
    .last      (last_w),
    .row_nxt_c (row_nxt),
    .col_nxt_c (col_nxt)
  );

  // Next state; a done_in landing on the final transfer edge recaptures without a bubble.
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    advance     = 1'b0;
    overflow_d  = 1'b0;
    cap_d       = cap_q;
    relu_d      = relu_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (done_in) begin
          if (size_ok) load = 1'b1;
          else         overflow_d = 1'b1;
        end
      end
      STREAM: begin
        if (xfer && last_w) begin
          advance = 1'b1;
          state_d = IDLE;
          if (done_in) begin
            if (size_ok) load = 1'b1;
            else         overflow_d = 1'b1;
          end
        end else begin
          if (xfer)    advance    = 1'b1;
          if (done_in) overflow_d = 1'b1;
        end
      end
    endcase

    if (load) begin
      state_d    = STREAM;
      cap_d      = data_in;
      relu_d     = relu_en;
      out_data_d = relu_f(data_in[0][0], relu_en);
    end else if (advance && (state_d == STREAM)) begin
      out_data_d = relu_f(cap_q[row_nxt][col_nxt], relu_q);
    end

    out_valid_d = (state_d == STREAM);
    busy_d      = (state_d == STREAM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  // Snapshot storage carries no reset; it is only read after a capture.
  always_ff @(posedge clk) begin
    cap_q  <= cap_d;
    relu_q <= relu_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = row_w;
  assign out_col   = col_w;
  assign out_last  = last_w;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/matmul_result_drain.md
# matmul_result_drain

Result-side drain for the matrix-multiply accelerator. On the accelerator's one-cycle completion pulse it snapshots the full DIM×DIM result matrix in parallel, with the active size m×p. It then streams only the valid m×p elements out in row-major order over a valid/ready interface, with optional ReLU. It frees the accelerator to restart immediately while the result is written back to memory by the downstream writer.

## Interface
- BITS, 8, width of one result element (two's complement)
- DIM, 32, maximum matrix dimension; sizes are $clog2(DIM)+1 bits wide
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- done_in  in  1  accelerator completion pulse; result valid in the same cycle
- m_in  in  $clog2(DIM)+1  result row count
- p_in  in  $clog2(DIM)+1  result column count
- data_in  in  BITS×[DIM][DIM]  parallel result matrix, [row][col]
- relu_en  in  1  clamp negative elements to 0
- out_valid  out  1  out_data holds an element
- out_ready  in  1  downstream accepts the element
- out_data  out  BITS  element value (after ReLU)
- out_row  out  $clog2(DIM)  row index of out_data
- out_col  out  $clog2(DIM)  column index of out_data
- out_last  out  1  marks element (m-1, p-1)
- busy  out  1  capture held or streaming
- overflow  out  1  one-cycle pulse: done_in dropped

## Operation
- FSM states:
  - IDLE: busy=0, out_valid=0.
  - STREAM: busy=1, out_valid=1.
- Capture in IDLE, on done_in=1:
  - latch data_in, m_in, p_in, relu_en;
  - row=col=0;
  - go to STREAM.
- Size rules:
  - m_in or p_in greater than DIM is clamped to DIM at capture.
  - m_in=0 or p_in=0: no capture, stay IDLE, pulse overflow.
- In STREAM:
  - out_data = relu ? (elem[BITS-1] ? 0 : elem) : elem, where elem = captured[row][col].
  - out_last = (row==m-1 && col==p-1).
- Handshake (transfer = out_valid && out_ready):
  - on transfer, col increments;
  - when col==p-1, col wraps to 0 and row increments;
  - on the last transfer, return to IDLE.
- Stall: while out_valid && !out_ready, out_data/out_row/out_col/out_last are held stable.
- Simultaneous events:
  - done_in on the same edge as the last transfer starts a new capture (back-to-back, no bubble); it is not an overflow.
  - done_in in STREAM at any other time is ignored, the captured data is untouched, and overflow pulses the next cycle.
- Values are passed through unmodified apart from ReLU; there is no saturation or width change.

## Timing
- Reset values: state=IDLE, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, overflow=0. The capture registers need not be reset.
- Latency:
  - done_in at edge N gives out_valid=1 with element (0,0) after edge N.
  - With out_ready held at 1, one element transfers per cycle, so m×p cycles from first to last transfer.
- After the last transfer edge, out_valid=0 unless a back-to-back capture occurred on that edge.
- overflow is registered and asserts in the cycle after the offending done_in edge.
- Reset mid-stream: all outputs go to their reset values immediately (asynchronous); the partial stream is abandoned and no resume occurs.
- out_ready may change at any time; the block has no combinational path from out_ready to out_valid.

## Structure
- Package matmul_pkg holds:
  - BITS and DIM defaults;
  - typedef dim_t (logic [$clog2(DIM):0]);
  - typedef idx_t (logic [$clog2(DIM)-1:0]);
  - enum drain_state_t {IDLE, STREAM}.
- Sub-module rc_walker: row/column index counter with parameters m, p. It takes an advance input and gives row, col and last outputs, resetting to (0,0) on load.
- The capture array and the output multiplexer live in the top module.

## Test plan
- 2×3 capture, data_in[r][c]=10r+c, out_ready=1, relu_en=0 -> 6 transfers on consecutive cycles: 0,1,2,10,11,12. out_last only on 12. busy falls after the 6th transfer.
- 4×4, relu_en=1, elements alternate 8'h85/8'h05, out_ready toggling every cycle -> output values are 0x00/0x05 only. Data is held stable during stalls. 16 transfers in 32 cycles.
- done_in pulsed in the same cycle as the last transfer of a 1×1 result -> the second matrix streams starting the next cycle, with no idle cycle and overflow=0.
- done_in during the 3rd element of an 8×8 stream -> overflow pulses once. The stream completes with the original data (64 elements).
- m_in=0, p_in=5 with done_in -> no out_valid, overflow pulses once. m_in=40 with DIM=32 -> 32 rows streamed.
- rst_n low after 10 of 32×32 elements -> outputs cleared immediately. A new done_in after release streams from (0,0).
